// File: rtl/rr_request_agent.sv
// Requester-side agent for the 4-way round-robin arbiter: per-client pending counters
// drive request lines; each accepted grant runs a fixed-length burst, then a one-cycle release.
//
//   state   | meaning
//   IDLE    | sampling grant, waiting for a one-hot grant to a requesting client
//   BURST   | driving beats 0..BURST_LEN-1 for the latched owner
//   RELEASE | one cycle with request[owner] forced low so the arbiter rotates
module rr_request_agent #(
    parameter int NCH       = 4,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3,
    localparam int SRC_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NCH-1:0]     push,
    input  logic [NCH-1:0]     grant,
    output logic [NCH-1:0]     request,
    output logic               bus_valid,
    output logic [SRC_W-1:0]   bus_src,
    output logic [3:0]         bus_beat,
    output logic [NCH-1:0]     done,
    output logic [NCH*CNT_W-1:0] pending,
    output logic               overflow,
    output logic               grant_err
);

    typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

    localparam logic [3:0]       LAST    = 4'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state, state_nx;
    logic [SRC_W-1:0]     owner, owner_nx;
    logic [SRC_W-1:0]     gidx;
    logic                 grant_multi, grant_one;
    logic                 complete;
    logic                 valid_nx;
    logic [SRC_W-1:0]     src_nx;
    logic [3:0]           beat_nx;
    logic [NCH-1:0]       done_nx;
    logic [NCH-1:0]       req_nx;
    logic [NCH*CNT_W-1:0] pend_nx;
    logic                 ovf_nx, gerr_nx;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) gidx = SRC_W'(i);
        end
        grant_multi = (grant & (grant - NCH'(1))) != '0;
        grant_one   = (grant != '0) && !grant_multi;
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        valid_nx = 1'b0;
        src_nx   = '0;
        beat_nx  = '0;
        done_nx  = '0;
        gerr_nx  = grant_err;
        complete = 1'b0;
        case (state)
            IDLE: begin
                // request is checked too, so a grant to an idle client is dropped
                if (grant_one && ((grant & request) != '0)) begin
                    state_nx      = BURST;
                    owner_nx      = gidx;
                    valid_nx      = 1'b1;
                    src_nx        = gidx;
                    done_nx[gidx] = (LAST == 4'd0);
                end else if (grant_multi) begin
                    gerr_nx = 1'b1;
                end
            end
            BURST: begin
                if (bus_beat == LAST) begin
                    complete = 1'b1;
                    state_nx = RELEASE;
                end else begin
                    valid_nx       = 1'b1;
                    src_nx         = owner;
                    beat_nx        = bus_beat + 4'd1;
                    done_nx[owner] = (beat_nx == LAST);
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pend_nx = pending;
        ovf_nx  = overflow;
        req_nx  = '0;
        for (int i = 0; i < NCH; i++) begin
            logic inc, dec;
            inc = push[i];
            dec = complete && (owner == SRC_W'(i));
            if (inc && !dec) begin
                if (pending[i*CNT_W +: CNT_W] == CNT_MAX) ovf_nx = 1'b1;
                else pend_nx[i*CNT_W +: CNT_W] = pending[i*CNT_W +: CNT_W] + CNT_W'(1);
            end else if (dec && !inc) begin
                pend_nx[i*CNT_W +: CNT_W] = pending[i*CNT_W +: CNT_W] - CNT_W'(1);
            end
            req_nx[i] = (pend_nx[i*CNT_W +: CNT_W] != '0) &&
                        !((state_nx == RELEASE) && (owner_nx == SRC_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= '0;
            request   <= '0;
            bus_valid <= 1'b0;
            bus_src   <= '0;
            bus_beat  <= '0;
            done      <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            request   <= req_nx;
            bus_valid <= valid_nx;
            bus_src   <= src_nx;
            bus_beat  <= beat_nx;
            done      <= done_nx;
            pending   <= pend_nx;
            overflow  <= ovf_nx;
            grant_err <= gerr_nx;
        end
    end

endmodule

// File: tb/tb_rr_request_agent.sv
// Directed bench for rr_request_agent: expected beats are queued when a grant is driven
// and popped as the bus produces them; all other checks are immediate assertions.
module tb_rr_request_agent;

    localparam int NCH = 4;
    localparam int BL  = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    push, grant;
    logic [3:0]    request;
    logic          bus_valid;
    logic [1:0]    bus_src;
    logic [3:0]    bus_beat;
    logic [3:0]    done;
    logic [11:0]   pending;
    logic          overflow, grant_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] src;
        logic [3:0] beat;
        logic [3:0] done;
    } exp_t;
    exp_t sb[$];

    rr_request_agent #(.NCH(NCH), .BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .push(push), .grant(grant),
        .request(request), .bus_valid(bus_valid), .bus_src(bus_src),
        .bus_beat(bus_beat), .done(done), .pending(pending),
        .overflow(overflow), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pend(input int i);
        return 32'(pending[i*CW +: CW]);
    endfunction

    // one clock, sample 1 time unit later, then score whatever the bus shows
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus_valid === 1'b1) begin
            chk("beat_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("bus_src",  32'(bus_src),  32'(e.src));
                chk("bus_beat", 32'(bus_beat), 32'(e.beat));
                chk("done",     32'(done),     32'(e.done));
            end
        end else begin
            chk("idle_done", 32'(done),     32'(0));
            chk("idle_src",  32'(bus_src),  32'(0));
            chk("idle_beat", 32'(bus_beat), 32'(0));
        end
    endtask

    task automatic queue_burst(input int idx);
        for (int b = 0; b < BL; b++) begin
            exp_t e;
            e.src  = 2'(idx);
            e.beat = 4'(b);
            e.done = (b == BL - 1) ? 4'(1 << idx) : 4'd0;
            sb.push_back(e);
        end
    endtask

    // starts from IDLE, ends one cycle after RELEASE (back in IDLE)
    task automatic run_burst(input int idx);
        queue_burst(idx);
        grant = 4'(1 << idx);
        tick();
        chk("first_beat_valid", 32'(bus_valid), 32'(1));
        grant = 4'd0;
        repeat (BL - 1) begin
            tick();
            chk("beat_valid", 32'(bus_valid), 32'(1));
        end
        tick();
        chk("release_valid", 32'(bus_valid), 32'(0));
        chk("release_req", 32'(request[idx]), 32'(0));
        chk("sb_drained", 32'(sb.size()), 32'(0));
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_request", 32'(request), 32'(0));
        chk("rst_valid", 32'(bus_valid), 32'(0));
        chk("rst_pending", 32'(pending), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_grant_err", 32'(grant_err), 32'(0));
    endtask

    initial begin
        reset = 1'b1;
        push  = 4'd0;
        grant = 4'd0;
        tick();
        do_reset();

        // single client burst
        push = 4'b0001;
        tick();
        push = 4'b0000;
        chk("t1_request", 32'(request), 32'(4'b0001));
        chk("t1_pend0", pend(0), 32'(1));
        run_burst(0);
        chk("t1_pend0_after", pend(0), 32'(0));
        chk("t1_request_after", 32'(request), 32'(0));

        // three back-to-back bursts
        push = 4'b1011;
        tick();
        push = 4'b0000;
        chk("t2_request", 32'(request), 32'(4'b1011));
        run_burst(0);
        chk("t2_req_a", 32'(request), 32'(4'b1010));
        run_burst(1);
        chk("t2_req_b", 32'(request), 32'(4'b1000));
        run_burst(3);
        chk("t2_req_c", 32'(request), 32'(0));
        chk("t2_pending", 32'(pending), 32'(0));

        // saturation of client 2
        for (int k = 1; k <= 8; k++) begin
            push = 4'b0100;
            tick();
            chk("t3_pend2", pend(2), 32'((k > 7) ? 7 : k));
            chk("t3_overflow", 32'(overflow), 32'(k == 8));
        end
        push = 4'b0000;
        tick();
        tick();
        chk("t3_overflow_sticky", 32'(overflow), 32'(1));
        chk("t3_req2", 32'(request), 32'(4'b0100));
        do_reset();

        // push coincident with last beat keeps pend0 at 1
        push = 4'b0001;
        tick();
        push = 4'b0000;
        queue_burst(0);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        tick();
        tick();
        tick();
        chk("t4_last_beat_valid", 32'(bus_valid), 32'(1));
        push = 4'b0001;
        tick();
        push = 4'b0000;
        chk("t4_release_valid", 32'(bus_valid), 32'(0));
        chk("t4_pend0", pend(0), 32'(1));
        chk("t4_release_req0", 32'(request[0]), 32'(0));
        tick();
        chk("t4_req0_back", 32'(request[0]), 32'(1));
        chk("t4_pend0_idle", pend(0), 32'(1));

        // multi-hot grant
        push = 4'b0010;
        tick();
        push = 4'b0000;
        chk("t5_request", 32'(request), 32'(4'b0011));
        grant = 4'b0011;
        tick();
        grant = 4'b0000;
        chk("t5_grant_err", 32'(grant_err), 32'(1));
        chk("t5_valid", 32'(bus_valid), 32'(0));
        tick();
        chk("t5_valid2", 32'(bus_valid), 32'(0));
        run_burst(1);
        chk("t5_request_after", 32'(request), 32'(4'b0001));
        chk("t5_grant_err_sticky", 32'(grant_err), 32'(1));

        // reset during beat 2
        queue_burst(0);
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
        tick();
        tick();
        chk("t6_beat2", 32'(bus_beat), 32'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        chk("t6_valid", 32'(bus_valid), 32'(0));
        chk("t6_done", 32'(done), 32'(0));
        chk("t6_pending", 32'(pending), 32'(0));
        chk("t6_request", 32'(request), 32'(0));
        chk("t6_grant_err", 32'(grant_err), 32'(0));
        repeat (4) begin
            tick();
            chk("t6_quiet", 32'(bus_valid), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_request_agent.md
Name: rr_request_agent

Overview:
- Requester-side companion to the 4-way round-robin arbiter: turns per-client transaction pushes into arbiter request lines and consumes the returned one-hot grant.
- On each accepted grant, runs a fixed-length burst on the shared bus on behalf of the granted client, then releases that client's request for one cycle so the arbiter rotates.
- Sits between the client logic and the arbiter; the shared-bus datapath sits downstream.

Parameters:
- NCH, 4, number of clients (request/grant width).
- BURST_LEN, 4, beats per granted transaction (range 1..16).
- CNT_W, 3, width of each per-client pending counter (maximum 2^CNT_W-1 pending).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  NCH  per-client one-cycle pulse; enqueues one transaction for that client; multiple bits may be high together.
- grant  input  NCH  one-hot grant from the arbiter.
- request  output  NCH  registered request lines to the arbiter.
- bus_valid  output  1  high during every burst beat.
- bus_src  output  log2(NCH)  index of the client owning the current beat.
- bus_beat  output  4  beat index within the burst, 0..BURST_LEN-1.
- done  output  NCH  one-cycle pulse on the owner's bit, coincident with the last beat.
- pending  output  NCH*CNT_W  packed per-client pending counts; client i occupies bits [i*CNT_W +: CNT_W].
- overflow  output  1  sticky; set when a push hits a saturated counter.
- grant_err  output  1  sticky; set when a multi-hot grant is sampled in IDLE.

Behaviour:
- Reset (synchronous, active-high): request=0, bus_valid=0, bus_src=0, bus_beat=0, done=0, all pending=0, overflow=0, grant_err=0, state=IDLE.
- Reset asserted mid-burst aborts the burst; no done pulse is produced; outputs take reset values on the next edge.
- Pending counters:
  - push[i] increments pend[i].
  - Completing a burst for i decrements pend[i].
  - Push and completion on the same client in the same cycle: net unchanged.
  - Push with pend[i] at maximum and no same-cycle completion: count holds, overflow is set.
- request[i] (registered) = 1 when pend[i] != 0 (using the next-state count), except that it is forced 0 for the client in RELEASE.
- FSM states: IDLE, BURST, RELEASE.
- IDLE:
  - Samples grant each cycle.
  - If grant is one-hot, grant[i]=1 and request[i]=1: latch owner=i, go to BURST. First beat appears on the next cycle, so grant-to-bus_valid latency is 1.
  - grant with popcount>1: set grant_err, ignore, stay in IDLE.
  - grant=0, or grant to a non-requesting client: ignore.
- BURST:
  - bus_valid=1, bus_src=owner, bus_beat counts 0..BURST_LEN-1, one beat per cycle.
  - request[owner] is held at 1 throughout so the arbiter keeps its grant.
  - On beat BURST_LEN-1: done[owner]=1 that cycle, pend[owner] decrements at that edge, go to RELEASE.
  - grant is ignored in BURST, including if it changes.
- RELEASE: exactly one cycle. bus_valid=0, request[owner]=0, other request bits follow their counters; then go to IDLE.
- The next burst can start no earlier than 2 cycles after the last beat (RELEASE cycle, then IDLE sampling).
- BURST_LEN=1: single-beat burst with bus_beat=0 and done in the same cycle.
- Outputs are glitch-free registers; done and bus_* are held 0 outside BURST.

Test Plan:
- Reset, then push=0001 at cycle 2 → request=0001 at cycle 3; drive grant=0001 → bus_valid high for 4 cycles, bus_src=0, bus_beat 0,1,2,3, done=0001 on beat 3, pend0 0, request=0000 afterwards.
- push=1011 once, arbiter grants 0001 → 0010 → 1000 → three back-to-back bursts, each followed by one RELEASE cycle with that request bit low; final pending all 0.
- Push client 2 eight times with CNT_W=3 → pend2 saturates at 7, overflow=1 and stays 1 until reset.
- Push client 0 in the same cycle as its last beat with pend0=1 → pend0 stays 1, request[0] low for the RELEASE cycle, then high again.
- In IDLE with pending 0011, drive grant=0011 → grant_err=1, bus_valid stays 0; then grant=0010 → burst with bus_src=1.
- Assert reset during beat 2 of a burst → next cycle bus_valid=0, done never pulses, pending=0, request=0000.
